ultrasonic_dist_filter: RTL and testbench

- Downstream consumer of the ultrasonic ranging block; accepts each finished distance measurement in cm with a one-cycle valid strobe.
- Produces a rounded moving average over 2^DEPTH_LOG2 samples.
- Rejects out-of-range readings and flags a sensor that has stopped reporting (stale).
- Output drives the FND/UART display path; an optional LED thermometer bar is also available.

---
 rtl/ultrasonic_pkg.sv | 20 ++
 rtl/ultrasonic_dist_filter_if.sv | 29 ++
 rtl/dist_led_bar.sv | 37 +++
 rtl/ultrasonic_dist_filter.sv | 157 +++++++++++++++
 tb/tb_ultrasonic_dist_filter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared constants and types for the ultrasonic distance filter.
// Holds the distance width, clock rate, default parameter values and the
// filter state type used by the top level.
package ultrasonic_pkg;

    localparam int unsigned DIST_W           = 16;
    localparam int unsigned CLK_HZ           = 125_000_000;
    localparam int unsigned DEF_DEPTH_LOG2   = 2;
    localparam int unsigned DEF_MIN_CM       = 2;
    localparam int unsigned DEF_MAX_CM       = 400;
    localparam int unsigned DEF_STALE_CYCLES = 12_500_000;

    // Filter states: waiting for first sample, averaging, sensor silent.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        RUN   = 2'd1,
        STALE = 2'd2
    } state_e;

endpackage

// File: rtl/ultrasonic_dist_filter_if.sv
// Measurement-in / average-out bundle of the distance filter.
//   dist_in, dist_valid       : finished measurement from the ranging block
//   dist_avg, avg_valid       : rounded window average and its update strobe
//   avg_ready, out_of_range   : window holds real data / last sample rejected
//   stale, LED_bar            : sensor silent / thermometer display
// master: measurement source and display consumer; slave: the filter.
interface ultrasonic_dist_filter_if;
    import ultrasonic_pkg::*;

    logic [DIST_W-1:0] dist_in;
    logic              dist_valid;
    logic [DIST_W-1:0] dist_avg;
    logic              avg_valid;
    logic              avg_ready;
    logic              out_of_range;
    logic              stale;
    logic [7:0]        LED_bar;

    modport master (
        output dist_in, dist_valid,
        input  dist_avg, avg_valid, avg_ready, out_of_range, stale, LED_bar
    );

    modport slave (
        input  dist_in, dist_valid,
        output dist_avg, avg_valid, avg_ready, out_of_range, stale, LED_bar
    );

endinterface

// File: rtl/dist_led_bar.sv
// Thermometer bar for the averaged distance: bit i lights when the window is
// ready and the average reaches (i+1)/8 of MAX_CM. Thresholds are fixed at
// elaboration. Inputs are the filter's next-state values so the bar register
// updates on the same edge as dist_avg.
//   clk, rst   : clock, async active-high reset
//   avg_d      : next dist_avg value
//   ready_d    : next avg_ready value
//   led_bar    : registered thermometer output
module dist_led_bar
    import ultrasonic_pkg::*;
#(
    parameter int unsigned MAX_CM = DEF_MAX_CM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] avg_d,
    input  logic              ready_d,
    output logic [7:0]        led_bar
);

    logic [7:0] hit_c;

    // One comparator per segment against a constant threshold.
    for (genvar i = 0; i < 8; i++) begin : g_seg
        localparam int unsigned TH = ((i + 1) * MAX_CM) / 8;
        assign hit_c[i] = ready_d && (avg_d >= DIST_W'(TH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_bar <= 8'h00;
        end else begin
            led_bar <= hit_c;
        end
    end

endmodule

// File: rtl/ultrasonic_dist_filter.sv
// Moving-average filter for ultrasonic distance readings.
// Accepts one measurement per cycle, rejects readings outside
// [MIN_CM, MAX_CM], keeps a rounded average over 2^DEPTH_LOG2 samples and
// flags a sensor that has been silent for STALE_CYCLES cycles while running.
// Optional LED thermometer bar: define ULTRASONIC_DIST_LED_BAR_EN.
//   clk      : system clock
//   rst      : async active-high reset
//   dist_if  : slave side of ultrasonic_dist_filter_if (see interface file)
module ultrasonic_dist_filter
    import ultrasonic_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int unsigned MIN_CM       = DEF_MIN_CM,
    parameter int unsigned MAX_CM       = DEF_MAX_CM,
    parameter int unsigned STALE_CYCLES = DEF_STALE_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    ultrasonic_dist_filter_if.slave  dist_if
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W = DIST_W + DEPTH_LOG2;
    localparam int unsigned RND_W = SUM_W + 1;
    localparam int unsigned HALF  = 1 << (DEPTH_LOG2 - 1);
    localparam int unsigned TMR_W = (STALE_CYCLES > 1) ? $clog2(STALE_CYCLES) : 1;

    localparam logic [1:0] ST_EMPTY = EMPTY;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_STALE = STALE;

    logic [1:0]            state_q,  state_d;
    logic [DIST_W-1:0]     ring_q [DEPTH];
    logic [SUM_W-1:0]      sum_q,    sum_d;
    logic [DEPTH_LOG2-1:0] wptr_q,   wptr_d;
    logic [TMR_W-1:0]      timer_q,  timer_d;
    logic [DIST_W-1:0]     avg_q,    avg_d;
    logic                  vld_q,    vld_d;
    logic                  ready_q,  ready_d;
    logic                  oor_q,    oor_d;
    logic                  stale_q,  stale_d;

    logic                  in_range_c;
    logic                  seed_c;
    logic                  write_c;
    logic [RND_W-1:0]      rnd_c;

    assign in_range_c = (dist_if.dist_in >= DIST_W'(MIN_CM)) &&
                        (dist_if.dist_in <= DIST_W'(MAX_CM));

    // State register and all registered datapath/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            sum_q   <= '0;
            wptr_q  <= '0;
            timer_q <= '0;
            avg_q   <= '0;
            vld_q   <= 1'b0;
            ready_q <= 1'b0;
            oor_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (seed_c) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    ring_q[i] <= dist_if.dist_in;
                end
            end else if (write_c) begin
                ring_q[wptr_q] <= dist_if.dist_in;
            end
            sum_q   <= sum_d;
            wptr_q  <= wptr_d;
            timer_q <= timer_d;
            avg_q   <= avg_d;
            vld_q   <= vld_d;
            ready_q <= ready_d;
            oor_q   <= oor_d;
            stale_q <= stale_d;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        wptr_d  = wptr_q;
        timer_d = timer_q;
        avg_d   = avg_q;
        vld_d   = 1'b0;
        ready_d = ready_q;
        oor_d   = oor_q;
        stale_d = stale_q;
        seed_c  = 1'b0;
        write_c = 1'b0;
        rnd_c   = '0;

        if (dist_if.dist_valid) begin
            // Any reading, good or bad, proves the sensor is alive.
            timer_d = '0;
            if (in_range_c) begin
                if (state_q == ST_RUN) begin
                    write_c = 1'b1;
                    sum_d   = sum_q - SUM_W'(ring_q[wptr_q]) + SUM_W'(dist_if.dist_in);
                    wptr_d  = wptr_q + DEPTH_LOG2'(1);
                end else begin
                    // First sample after reset or silence fills the whole window.
                    seed_c  = 1'b1;
                    sum_d   = SUM_W'(dist_if.dist_in) << DEPTH_LOG2;
                    wptr_d  = '0;
                end
                rnd_c   = RND_W'(sum_d) + RND_W'(HALF);
                avg_d   = DIST_W'(rnd_c >> DEPTH_LOG2);
                vld_d   = 1'b1;
                ready_d = 1'b1;
                oor_d   = 1'b0;
                stale_d = 1'b0;
                state_d = ST_RUN;
            end else begin
                oor_d = 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            if (timer_q == TMR_W'(STALE_CYCLES - 1)) begin
                state_d = ST_STALE;
                stale_d = 1'b1;
                ready_d = 1'b0;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    assign dist_if.dist_avg     = avg_q;
    assign dist_if.avg_valid    = vld_q;
    assign dist_if.avg_ready    = ready_q;
    assign dist_if.out_of_range = oor_q;
    assign dist_if.stale        = stale_q;

`ifdef ULTRASONIC_DIST_LED_BAR_EN
    dist_led_bar #(
        .MAX_CM  (MAX_CM)
    ) u_led_bar (
        .clk     (clk),
        .rst     (rst),
        .avg_d   (avg_d),
        .ready_d (ready_d),
        .led_bar (dist_if.LED_bar)
    );
`else
    assign dist_if.LED_bar = 8'h00;
`endif

endmodule

// File: tb/tb_ultrasonic_dist_filter.sv
// Self-checking bench for ultrasonic_dist_filter: directed scenarios plus
// random traffic against a window-queue reference model with a scoreboard.
module tb_ultrasonic_dist_filter;
    import ultrasonic_pkg::*;

    localparam int unsigned DEPTH_LOG2   = 2;
    localparam int unsigned WIN          = 1 << DEPTH_LOG2;
    localparam int unsigned MIN_CM       = 2;
    localparam int unsigned MAX_CM       = 400;
    localparam int unsigned STALE_CYCLES = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ultrasonic_dist_filter_if dif ();

    ultrasonic_dist_filter #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .MIN_CM       (MIN_CM),
        .MAX_CM       (MAX_CM),
        .STALE_CYCLES (STALE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .dist_if (dif.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int sb_q[$];
    int window[$];
    bit running;
    int idle;
    int exp_avg;
    bit exp_valid, exp_ready, exp_oor, exp_stale;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int led_exp();
        int v;
        v = 0;
`ifdef ULTRASONIC_DIST_LED_BAR_EN
        for (int i = 0; i < 8; i++)
            if (exp_ready && exp_avg >= ((i + 1) * int'(MAX_CM)) / 8) v |= (1 << i);
`endif
        return v;
    endfunction

    task automatic model_reset();
        sb_q.delete();
        window.delete();
        running   = 0;
        idle      = 0;
        exp_avg   = 0;
        exp_valid = 0;
        exp_ready = 0;
        exp_oor   = 0;
        exp_stale = 0;
    endtask

    // Predicts the DUT outputs after the edge that captures (v, d).
    task automatic model_step(input bit v, input int d);
        int sum;
        exp_valid = 0;
        if (v) begin
            idle = 0;
            if (d >= int'(MIN_CM) && d <= int'(MAX_CM)) begin
                if (!running) begin
                    window.delete();
                    repeat (WIN) window.push_back(d);
                end else begin
                    void'(window.pop_front());
                    window.push_back(d);
                end
                running = 1;
                sum = 0;
                foreach (window[i]) sum += window[i];
                exp_avg   = (sum + WIN / 2) / WIN;
                exp_valid = 1;
                exp_ready = 1;
                exp_stale = 0;
                exp_oor   = 0;
                sb_q.push_back(exp_avg);
            end else begin
                exp_oor = 1;
            end
        end else if (running) begin
            idle++;
            if (idle >= int'(STALE_CYCLES)) begin
                running   = 0;
                exp_stale = 1;
                exp_ready = 0;
                idle      = 0;
            end
        end
    endtask

    task automatic cycle(input bit v, input int d);
        @(negedge clk);
        dif.dist_valid = v;
        dif.dist_in    = 16'(d);
        model_step(v, d);
    endtask

    task automatic idle_n(input int n);
        repeat (n) cycle(1'b0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avg"},   int'(dif.dist_avg), 0);
        check({tag, "_vld"},   int'(dif.avg_valid), 0);
        check({tag, "_rdy"},   int'(dif.avg_ready), 0);
        check({tag, "_oor"},   int'(dif.out_of_range), 0);
        check({tag, "_stale"}, int'(dif.stale), 0);
        check({tag, "_led"},   int'(dif.LED_bar), 0);
    endtask

    // Monitor: per-cycle status compare plus scoreboard pop on avg_valid.
    int popped;
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            check("avg_valid", int'(dif.avg_valid), int'(exp_valid));
            if (dif.avg_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got avg_valid=1 expected no pending sample at %0t", $time);
                end else begin
                    popped = sb_q.pop_front();
                    check("sb_avg", int'(dif.dist_avg), popped);
                end
            end
            check("dist_avg",     int'(dif.dist_avg), exp_avg);
            check("avg_ready",    int'(dif.avg_ready), int'(exp_ready));
            check("out_of_range", int'(dif.out_of_range), int'(exp_oor));
            check("stale",        int'(dif.stale), int'(exp_stale));
            check("LED_bar",      int'(dif.LED_bar), led_exp());
        end
    end

    int r;
    int d;

    initial begin
        dif.dist_valid = 1'b0;
        dif.dist_in    = '0;
        model_reset();

        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Seed and running average
        cycle(1, 100);
        @(posedge clk); #1;
        check("seed_avg", int'(dif.dist_avg), 100);
        check("seed_vld", int'(dif.avg_valid), 1);
        check("seed_rdy", int'(dif.avg_ready), 1);
        check("seed_stale", int'(dif.stale), 0);
        cycle(1, 104); @(posedge clk); #1; check("avg_104", int'(dif.dist_avg), 101);
        cycle(1, 108); @(posedge clk); #1; check("avg_108", int'(dif.dist_avg), 103);
        cycle(1, 112); @(posedge clk); #1; check("avg_112", int'(dif.dist_avg), 106);

        // Rejection holds the average and sets the sticky flag
        cycle(1, 500); @(posedge clk); #1;
        check("rej_oor", int'(dif.out_of_range), 1);
        check("rej_vld", int'(dif.avg_valid), 0);
        check("rej_avg", int'(dif.dist_avg), 106);
        cycle(1, 106); @(posedge clk); #1;
        check("clr_oor", int'(dif.out_of_range), 0);

        // Range boundaries, back to back
        cycle(1, 1);
        cycle(1, 2);
        cycle(1, 400);
        cycle(1, 401);
        cycle(1, 0);
        cycle(1, 65535);
        cycle(1, 250);

        // Sample on the expiry cycle wins
        idle_n(STALE_CYCLES - 1);
        @(posedge clk); #1;
        check("pre_expiry_stale", int'(dif.stale), 0);
        cycle(1, 77); @(posedge clk); #1;
        check("expiry_race_stale", int'(dif.stale), 0);
        check("expiry_race_rdy", int'(dif.avg_ready), 1);

        // Full silence enters STALE, next sample reseeds
        idle_n(STALE_CYCLES);
        @(posedge clk); #1;
        check("stale_set", int'(dif.stale), 1);
        check("stale_rdy", int'(dif.avg_ready), 0);
        idle_n(5);
        cycle(1, 999);
        cycle(1, 50); @(posedge clk); #1;
        check("reseed_avg", int'(dif.dist_avg), 50);
        check("reseed_stale", int'(dif.stale), 0);
        check("reseed_rdy", int'(dif.avg_ready), 1);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                case ($urandom_range(0, 9))
                    0:       d = int'(MIN_CM) - 1 + int'($urandom_range(0, 1));
                    1:       d = int'(MAX_CM) + int'($urandom_range(0, 1));
                    2:       d = int'($urandom_range(0, 65535));
                    default: d = int'($urandom_range(0, 420));
                endcase
                cycle(1, d);
            end else begin
                cycle(0, 0);
            end
        end

        // Asynchronous reset mid-run
        cycle(1, 300);
        cycle(1, 310);
        cycle(0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1, 450); @(posedge clk); #1;
        check("empty_rej_oor", int'(dif.out_of_range), 1);
        check("empty_rej_rdy", int'(dif.avg_ready), 0);
        cycle(1, 200); @(posedge clk); #1;
        check("post_rst_avg", int'(dif.dist_avg), 200);
        cycle(1, 210);
        cycle(1, 220);
        idle_n(4);

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
